// File: rtl/run_pattern_gen.sv
// run_pattern_gen: serial run-length pattern transmitter.
// Takes (bit, length) requests over valid/ready. It emits one bit per clk on
// `out` and, in the same cycle, `exp_hit`: the value a run detector with
// threshold DET_LEN must produce for that bit.
// Optional feature macro: IDLE_TOGGLE_EN. When defined, `out` toggles during
// idle cycles. When undefined, `out` holds the last emitted bit.
//
// Handshake: a request transfers on a rising edge where req_valid && req_ready.
// req_ready is combinational from state and remaining only, never from
// req_valid. A request may be presented at any time and held until it is
// taken. A zero-length request is taken and discarded.
module run_pattern_gen #(
  parameter int LEN_W   = 4,
  parameter int DET_LEN = 4
) (
  input  logic             clk,
  input  logic             nRESET,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_bit,
  input  logic [LEN_W-1:0] req_len,
  output logic             out,
  output logic             out_valid,
  output logic             exp_hit,
  output logic             last_bit,
  output logic             dbg_state   // 0 = IDLE, 1 = SEND
);

  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

  localparam logic [LEN_W-1:0] CNT_MAX = LEN_W'(DET_LEN);

  state_t           r_state;
  logic [LEN_W-1:0] r_remaining;
  logic [LEN_W-1:0] r_run_cnt;
  logic             r_prev_bit;
  logic             r_out;
  logic             r_out_valid;
  logic             r_exp_hit;
  logic             r_last_bit;

  state_t           w_state_n;
  logic [LEN_W-1:0] w_remaining_n;
  logic [LEN_W-1:0] w_run_cnt_n;
  logic             w_prev_bit_n;
  logic             w_out_n;
  logic             w_out_valid_n;
  logic             w_exp_hit_n;
  logic             w_last_bit_n;
  logic             w_emit;
  logic             w_emit_bit;
  logic             w_load;

  assign req_ready = (r_state == IDLE) ||
                     (r_state == SEND && r_remaining == LEN_W'(1));
  assign w_load    = req_valid && req_ready && (req_len != '0);

  assign out       = r_out;
  assign out_valid = r_out_valid;
  assign exp_hit   = r_exp_hit;
  assign last_bit  = r_last_bit;
  assign dbg_state = r_state;

  // Next-state, next bit to emit and run tracking for the emitted bit.
  always_comb begin
    w_state_n     = r_state;
    w_remaining_n = r_remaining;
    w_emit        = 1'b0;
    w_emit_bit    = r_prev_bit;
    case (r_state)
      IDLE: begin
        if (w_load) begin
          w_state_n     = SEND;
          w_remaining_n = req_len;
          w_emit        = 1'b1;
          w_emit_bit    = req_bit;
        end
      end
      SEND: begin
        if (r_remaining > LEN_W'(1)) begin
          w_remaining_n = r_remaining - LEN_W'(1);
          w_emit        = 1'b1;
          w_emit_bit    = r_prev_bit;  // r_prev_bit is the bit on out now
        end else if (w_load) begin
          w_remaining_n = req_len;
          w_emit        = 1'b1;
          w_emit_bit    = req_bit;
        end else begin
          w_state_n     = IDLE;
          w_remaining_n = '0;
        end
      end
      default: begin
        w_state_n     = IDLE;
        w_remaining_n = '0;
      end
    endcase

    w_prev_bit_n  = r_prev_bit;
    w_run_cnt_n   = '0;
    w_out_valid_n = 1'b0;
    w_exp_hit_n   = 1'b0;
    w_last_bit_n  = 1'b0;
`ifdef IDLE_TOGGLE_EN
    // After a valid bit, r_out == r_prev_bit, so this starts from ~prev_bit.
    w_out_n       = ~r_out;
`else
    w_out_n       = r_out;
`endif
    if (w_emit) begin
      if (r_out_valid && (w_emit_bit == r_prev_bit))
        w_run_cnt_n = (r_run_cnt >= CNT_MAX) ? CNT_MAX : r_run_cnt + LEN_W'(1);
      else
        w_run_cnt_n = LEN_W'(1);
      w_out_n       = w_emit_bit;
      w_prev_bit_n  = w_emit_bit;
      w_out_valid_n = 1'b1;
      w_exp_hit_n   = (w_run_cnt_n >= CNT_MAX);
      w_last_bit_n  = (w_remaining_n == LEN_W'(1));
    end
  end

  // State and registered outputs; asynchronous active-low reset.
  always_ff @(posedge clk or negedge nRESET) begin
    if (!nRESET) begin
      r_state     <= IDLE;
      r_remaining <= '0;
      r_run_cnt   <= '0;
      r_prev_bit  <= 1'b0;
      r_out       <= 1'b0;
      r_out_valid <= 1'b0;
      r_exp_hit   <= 1'b0;
      r_last_bit  <= 1'b0;
    end else begin
      r_state     <= w_state_n;
      r_remaining <= w_remaining_n;
      r_run_cnt   <= w_run_cnt_n;
      r_prev_bit  <= w_prev_bit_n;
      r_out       <= w_out_n;
      r_out_valid <= w_out_valid_n;
      r_exp_hit   <= w_exp_hit_n;
      r_last_bit  <= w_last_bit_n;
    end
  end

endmodule

// File: tb/tb_run_pattern_gen.sv
// Directed testbench for run_pattern_gen (default build, IDLE_TOGGLE_EN undefined).
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_run_pattern_gen;

  localparam int LEN_W = 4;

  logic             clk;
  logic             nRESET;
  logic             req_valid;
  logic             req_ready;
  logic             req_bit;
  logic [LEN_W-1:0] req_len;
  logic             out;
  logic             out_valid;
  logic             exp_hit;
  logic             last_bit;
  logic             dbg_state;

  int n_checks = 0;
  int n_errors = 0;

  run_pattern_gen #(.LEN_W(LEN_W), .DET_LEN(4)) dut (
    .clk       (clk),
    .nRESET    (nRESET),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_bit   (req_bit),
    .req_len   (req_len),
    .out       (out),
    .out_valid (out_valid),
    .exp_hit   (exp_hit),
    .last_bit  (last_bit),
    .dbg_state (dbg_state)
  );

  // Clock generation.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic drive_req(input logic b, input int len);
    req_valid = 1'b1;
    req_bit   = b;
    req_len   = LEN_W'(len);
  endtask

  task automatic drive_idle();
    req_valid = 1'b0;
    req_bit   = 1'b0;
    req_len   = '0;
  endtask

  // Advance to the next falling edge and compare all serial outputs.
  task automatic expect_bit(input string tag, input logic o, input logic ov,
                            input logic hit, input logic last);
    @(negedge clk);
    check_eq({tag, ".out"},       32'(out),       32'(o));
    check_eq({tag, ".out_valid"}, 32'(out_valid), 32'(ov));
    check_eq({tag, ".exp_hit"},   32'(exp_hit),   32'(hit));
    check_eq({tag, ".last_bit"},  32'(last_bit),  32'(last));
  endtask

  initial begin
    nRESET = 1'b0;
    drive_idle();
    repeat (3) @(negedge clk);
    check_eq("rst.out",       32'(out),       0);
    check_eq("rst.out_valid", 32'(out_valid), 0);
    check_eq("rst.exp_hit",   32'(exp_hit),   0);
    check_eq("rst.last_bit",  32'(last_bit),  0);
    check_eq("rst.req_ready", 32'(req_ready), 1);
    check_eq("rst.state",     32'(dbg_state), 0);
    nRESET = 1'b1;
    expect_bit("idle0", 1'b0, 1'b0, 1'b0, 1'b0);

    // Test 1: run of four zeros, hit on the fourth bit.
    drive_req(1'b0, 4);
    expect_bit("t1.b1", 1'b0, 1'b1, 1'b0, 1'b0);
    check_eq("t1.ready_mid", 32'(req_ready), 0);
    check_eq("t1.state_mid", 32'(dbg_state), 1);
    drive_idle();
    expect_bit("t1.b2", 1'b0, 1'b1, 1'b0, 1'b0);
    expect_bit("t1.b3", 1'b0, 1'b1, 1'b0, 1'b0);
    expect_bit("t1.b4", 1'b0, 1'b1, 1'b1, 1'b1);
    check_eq("t1.ready_last", 32'(req_ready), 1);
    expect_bit("t1.idle", 1'b0, 1'b0, 1'b0, 1'b0);

    // Test 2: two runs of three ones separated by a gap; no hit.
    drive_req(1'b1, 3);
    expect_bit("t2.a1", 1'b1, 1'b1, 1'b0, 1'b0);
    drive_idle();
    expect_bit("t2.a2", 1'b1, 1'b1, 1'b0, 1'b0);
    expect_bit("t2.a3", 1'b1, 1'b1, 1'b0, 1'b1);
    expect_bit("t2.gap", 1'b1, 1'b0, 1'b0, 1'b0);
    drive_req(1'b1, 3);
    expect_bit("t2.b1", 1'b1, 1'b1, 1'b0, 1'b0);
    drive_idle();
    expect_bit("t2.b2", 1'b1, 1'b1, 1'b0, 1'b0);
    expect_bit("t2.b3", 1'b1, 1'b1, 1'b0, 1'b1);
    expect_bit("t2.idle", 1'b1, 1'b0, 1'b0, 1'b0);

    // Test 3: (0,2) then (0,3) back-to-back -> five contiguous zeros.
    drive_req(1'b0, 2);
    expect_bit("t3.b1", 1'b0, 1'b1, 1'b0, 1'b0);
    drive_idle();
    expect_bit("t3.b2", 1'b0, 1'b1, 1'b0, 1'b1);
    drive_req(1'b0, 3);
    expect_bit("t3.b3", 1'b0, 1'b1, 1'b0, 1'b0);
    drive_idle();
    expect_bit("t3.b4", 1'b0, 1'b1, 1'b1, 1'b0);
    expect_bit("t3.b5", 1'b0, 1'b1, 1'b1, 1'b1);
    expect_bit("t3.idle", 1'b0, 1'b0, 1'b0, 1'b0);

    // Test 4: (1,3) then (0,5) back-to-back; hit on 4th and 5th zero.
    drive_req(1'b1, 3);
    expect_bit("t4.b1", 1'b1, 1'b1, 1'b0, 1'b0);
    drive_idle();
    expect_bit("t4.b2", 1'b1, 1'b1, 1'b0, 1'b0);
    expect_bit("t4.b3", 1'b1, 1'b1, 1'b0, 1'b1);
    drive_req(1'b0, 5);
    expect_bit("t4.b4", 1'b0, 1'b1, 1'b0, 1'b0);
    drive_idle();
    expect_bit("t4.b5", 1'b0, 1'b1, 1'b0, 1'b0);
    expect_bit("t4.b6", 1'b0, 1'b1, 1'b0, 1'b0);
    expect_bit("t4.b7", 1'b0, 1'b1, 1'b1, 1'b0);
    expect_bit("t4.b8", 1'b0, 1'b1, 1'b1, 1'b1);
    expect_bit("t4.idle", 1'b0, 1'b0, 1'b0, 1'b0);

    // Test 5: zero-length request is discarded, then (1,15) saturates.
    drive_req(1'b0, 0);
    expect_bit("t5.zero", 1'b0, 1'b0, 1'b0, 1'b0);
    check_eq("t5.ready", 32'(req_ready), 1);
    check_eq("t5.state", 32'(dbg_state), 0);
    drive_req(1'b1, 15);
    for (int i = 1; i <= 15; i++) begin
      expect_bit($sformatf("t5.b%0d", i), 1'b1, 1'b1, (i >= 4), (i == 15));
      drive_idle();
    end
    expect_bit("t5.idle", 1'b1, 1'b0, 1'b0, 1'b0);

    // Test 6: reset asserted during bit 2 of (0,6).
    drive_req(1'b0, 6);
    expect_bit("t6.b1", 1'b0, 1'b1, 1'b0, 1'b0);
    drive_idle();
    expect_bit("t6.b2", 1'b0, 1'b1, 1'b0, 1'b0);
    nRESET = 1'b0;
    #1;
    check_eq("t6.rst.out_valid", 32'(out_valid), 0);
    check_eq("t6.rst.last_bit",  32'(last_bit),  0);
    check_eq("t6.rst.exp_hit",   32'(exp_hit),   0);
    check_eq("t6.rst.state",     32'(dbg_state), 0);
    @(negedge clk);
    nRESET = 1'b1;
    for (int i = 0; i < 3; i++)
      expect_bit($sformatf("t6.after%0d", i), 1'b0, 1'b0, 1'b0, 1'b0);
    check_eq("t6.ready", 32'(req_ready), 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
